// File: rtl/axis_pkt_gen_if.sv
// 8-bit AXI-Stream bus carried between the packet generator and its sink.
// The master drives data/valid/last and the slave drives ready.
interface axis_pkt_gen_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source: on start, emits len beats of an incrementing byte pattern from seed.
// Optional trailing XOR checksum beat is enabled by defining AXIS_PKT_CSUM_EN.
module axis_pkt_gen #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       seed,
  output logic             busy,
  output logic             done,
  axis_pkt_gen_if.master   m
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND
`ifdef AXIS_PKT_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;
  logic             hs_d;
  logic [7:0]       data_inc_d;
`ifdef AXIS_PKT_CSUM_EN
  logic [7:0]       csum_q;
`endif

  assign hs_d       = valid_q && m.m_ready;
  assign data_inc_d = data_q + 8'd1;

  assign m.m_data  = data_q;
  assign m.m_valid = valid_q;
  assign m.m_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // cnt_q holds the number of payload beats still to follow the one on the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AXIS_PKT_CSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && (len != '0)) begin
            state_q <= S_SEND;
            cnt_q   <= len - LEN_W'(1);
            data_q  <= seed;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
`ifdef AXIS_PKT_CSUM_EN
            last_q  <= 1'b0;
            csum_q  <= 8'h00;
`else
            last_q  <= (len == LEN_W'(1));
`endif
          end
        end
        S_SEND: begin
          if (hs_d) begin
            if (cnt_q == '0) begin
`ifdef AXIS_PKT_CSUM_EN
              // Final payload byte folds into the checksum presented as the next beat.
              state_q <= S_CSUM;
              data_q  <= csum_q ^ data_q;
              csum_q  <= csum_q ^ data_q;
              last_q  <= 1'b1;
`else
              state_q <= S_IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              cnt_q  <= cnt_q - LEN_W'(1);
              data_q <= data_inc_d;
`ifdef AXIS_PKT_CSUM_EN
              csum_q <= csum_q ^ data_q;
`else
              last_q <= (cnt_q == LEN_W'(1));
`endif
            end
          end
        end
`ifdef AXIS_PKT_CSUM_EN
        S_CSUM: begin
          if (hs_d) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: directed scenarios plus randomized packets and back-pressure.
// Expected beats come from a queue built as seed+i (and their XOR when AXIS_PKT_CSUM_EN is defined).
module tb_axis_pkt_gen;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] len;
  logic [7:0] seed;
  logic       busy;
  logic       done;
  int         vectors = 0;
  int         miscompares = 0;

  axis_pkt_gen_if pif ();

  axis_pkt_gen #(.LEN_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .len     (len),
    .seed    (seed),
    .busy    (busy),
    .done    (done),
    .m       (pif.master)
  );

  always #5 clk = ~clk;

  function automatic void build_pkt(input logic [7:0] sd, input int ln, output logic [7:0] q[$]);
    logic [7:0] x;
    x = 8'h00;
    q = {};
    for (int i = 0; i < ln; i++) begin
      q.push_back(8'(sd + i));
      x = x ^ 8'(sd + i);
    end
`ifdef AXIS_PKT_CSUM_EN
    q.push_back(x);
`endif
  endfunction

  task automatic send_pkt(input logic [7:0] sd, input int ln, input int stall_pct,
                          input int stall_at, input int stall_n, input bit mid_start);
    logic [7:0] exp_q[$];
    int idx, stalls, cyc;
    bit rdy, fired;
    idx = 0; stalls = 0; cyc = 0; fired = 0;
    build_pkt(sd, ln, exp_q);
    @(negedge clk);
    start = 1'b1; len = 8'(ln); seed = sd;
    pif.m_ready = 1'($urandom_range(1));
    @(negedge clk);
    start = 1'b0;
    while (idx < exp_q.size() && cyc < 2000) begin
      vectors++;
      if (pif.m_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL pkt_ctrl seed=%h beat=%0d: valid=%b busy=%b done=%b, need 1 1 0",
                 sd, idx, pif.m_valid, busy, done);
      end
      vectors++;
      if (pif.m_data !== exp_q[idx] || pif.m_last !== 1'(idx == exp_q.size() - 1)) begin
        miscompares++;
        $display("FAIL pkt_beat seed=%h beat=%0d: data=%h last=%b, need data=%h last=%b",
                 sd, idx, pif.m_data, pif.m_last, exp_q[idx], idx == exp_q.size() - 1);
      end
      start = 1'b0;
      if (mid_start && idx == 1 && !fired) begin
        start = 1'b1; seed = 8'h99; len = 8'd3; fired = 1'b1;
      end
      if (idx == stall_at && stalls < stall_n) rdy = 1'b0;
      else rdy = ($urandom_range(99) >= stall_pct);
      if (idx == stall_at && !rdy) stalls++;
      pif.m_ready = rdy;
      if (rdy) idx++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (cyc >= 2000) begin
      miscompares++;
      $display("FAIL pkt_timeout seed=%h: %0d of %0d beats seen", sd, idx, exp_q.size());
    end
    vectors++;
    if (pif.m_valid !== 1'b0 || pif.m_last !== 1'b0 || busy !== 1'b0 || done !== 1'b1 ||
        pif.m_data !== exp_q[exp_q.size() - 1]) begin
      miscompares++;
      $display("FAIL pkt_done seed=%h: valid=%b last=%b busy=%b done=%b data=%h, need 0 0 0 1 %h",
               sd, pif.m_valid, pif.m_last, busy, done, pif.m_data, exp_q[exp_q.size() - 1]);
    end
    pif.m_ready = 1'($urandom_range(1));
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || pif.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pkt_after_done seed=%h: done=%b valid=%b, need 0 0", sd, done, pif.m_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; len = 8'd4; seed = 8'h10; pif.m_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (pif.m_valid !== 1'b0 || pif.m_last !== 1'b0 || pif.m_data !== 8'h00 ||
          busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: valid=%b last=%b data=%h busy=%b done=%b, need all 0",
                 pif.m_valid, pif.m_last, pif.m_data, busy, done);
      end
    end
    start = 1'b0;
    reset_n = 1'b1;
    send_pkt(8'h10, 4, 0, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    send_pkt(8'h10, 4, 0, 1, 3, 1'b0);
  endtask

  task automatic test_wrap_single();
    send_pkt(8'hFE, 4, 0, -1, 0, 1'b0);
    send_pkt(8'h55, 1, 0, -1, 0, 1'b0);
    send_pkt(8'h55, 1, 0, 0, 2, 1'b0);
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    start = 1'b1; len = 8'd0; seed = 8'h42; pif.m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      vectors++;
      if (pif.m_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL len_zero: valid=%b done=%b busy=%b, need 0 0 0", pif.m_valid, done, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_start();
    send_pkt(8'h20, 4, 0, -1, 0, 1'b1);
    send_pkt(8'h70, 6, 40, -1, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int cyc;
    build_pkt(8'h30, 2, exp_q);
    @(negedge clk);
    start = 1'b1; len = 8'd2; seed = 8'h30; pif.m_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < exp_q.size(); k++) begin
      vectors++;
      if (pif.m_valid !== 1'b1 || pif.m_data !== exp_q[k]) begin
        miscompares++;
        $display("FAIL b2b_first beat=%0d: valid=%b data=%h, need 1 %h", k, pif.m_valid, pif.m_data, exp_q[k]);
      end
      @(negedge clk);
    end
    vectors++;
    if (done !== 1'b1 || pif.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap: done=%b valid=%b, need 1 0", done, pif.m_valid);
    end
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (pif.m_valid !== 1'b1 || pif.m_data !== exp_q[0] || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: valid=%b data=%h busy=%b, need 1 %h 1", pif.m_valid, pif.m_data, busy, exp_q[0]);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc >= 100) begin
      miscompares++;
      $display("FAIL b2b_drain: no done within %0d cycles", cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] sd;
    int cyc;
    sd = 8'($urandom);
    @(negedge clk);
    start = 1'b1; len = 8'd8; seed = sd; pif.m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (pif.m_data !== 8'(sd + 2) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc >= 50) begin
      miscompares++;
      $display("FAIL rstmid_wait: beat 2 (%h) never seen", 8'(sd + 2));
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (pif.m_valid !== 1'b0 || pif.m_last !== 1'b0 || busy !== 1'b0 || pif.m_data !== 8'h00) begin
      miscompares++;
      $display("FAIL rstmid_async: valid=%b last=%b busy=%b data=%h, need 0 0 0 00",
               pif.m_valid, pif.m_last, busy, pif.m_data);
    end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || pif.m_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_hold: done=%b valid=%b, need 0 0", done, pif.m_valid);
      end
    end
    reset_n = 1'b1;
    send_pkt(sd, 8, 20, -1, 0, 1'b0);
  endtask

  task automatic test_csum();
    send_pkt(8'hA0, 2, 0, -1, 0, 1'b0);
    send_pkt(8'h01, 3, 0, 3, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      send_pkt(8'($urandom), int'($urandom_range(20, 1)), int'($urandom_range(60)), -1, 0, 1'($urandom_range(1)));
    end
    send_pkt(8'($urandom), 255, 10, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_wrap_single();
    test_len_zero();
    test_mid_start();
    test_back_to_back();
    test_reset_mid();
    test_csum();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
